axis_ifft_8point: RTL and testbench

- 8-point inverse DFT with AXI-Stream on both sides; the return path of the 8-point FFT block.
- Accepts one 512-bit beat holding 8 complex bins X[0..7] in the FFT output format.
- Emits one 64-bit beat holding 8 real Q7 time samples x[0..7].
- Radix-2 DIT pipeline with conjugate twiddles, 1/8 scaling, rounding and Q7 saturation; flags saturation per beat.

---
 rtl/ifft8_pkg.sv | 41 ++++
 rtl/ifft_cbfly.sv | 56 +++++
 rtl/axis_ifft_8point.sv | 124 ++++++++++++
 tb/tb_axis_ifft_8point.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft8_pkg.sv
// Shared widths, twiddle constant, Q7 limits and the output round/saturate helper
// for the 8-point inverse FFT.
package ifft8_pkg;

  localparam int IW        = 35;     // internal datapath width (32-bit bins + 3 bits of growth)
  localparam int PW        = 48;     // twiddle product width
  localparam int C_TW      = 23170;  // cos(pi/4) in Q15
  localparam int TW_SHIFT  = 15;
  localparam int Q7_MAX    = 127;
  localparam int Q7_MIN    = -128;
  localparam int RND_ADD   = 4;
  localparam int RND_SHIFT = 3;

  typedef struct packed {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    TW_ONE  = 2'd0,
    TW_J    = 2'd1,
    TW_CJC  = 2'd2,
    TW_NCJC = 2'd3
  } tw_e;

  // Divide by 8 with round-half-up, then clamp; bit 8 of the result flags saturation.
  function automatic logic [8:0] q7_round_sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] y;
    logic [8:0]           r;
    y = (v + IW'(RND_ADD)) >>> RND_SHIFT;
    if (y > IW'(Q7_MAX)) begin
      r = {1'b1, 8'h7F};
    end else if (y < IW'(Q7_MIN)) begin
      r = {1'b1, 8'h80};
    end else begin
      r = {1'b0, y[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_cbfly.sv
// Combinational complex butterfly: sum = a + W*b, diff = a - W*b,
// W chosen from {1, +j, c+jc, -c+jc} (the conjugate twiddles of the inverse transform).
module ifft_cbfly
  import ifft8_pkg::*;
(
  input  logic [2*IW-1:0] a_i,
  input  logic [2*IW-1:0] b_i,
  input  logic [1:0]      sel_i,
  output logic [2*IW-1:0] sum_o,
  output logic [2*IW-1:0] diff_o
);

  cplx_t a, b, t, s, d;
  tw_e   sel;
  logic signed [PW-1:0] pr, pi;

  assign a   = a_i;
  assign b   = b_i;
  assign sel = tw_e'(sel_i);

  assign pr = PW'($signed(b.re)) * PW'(C_TW);
  assign pi = PW'($signed(b.im)) * PW'(C_TW);

  // Products floor on the arithmetic shift; only the c+jc / -c+jc paths round.
  always_comb begin
    t = b;
    case (sel)
      TW_ONE: begin
        t = b;
      end
      TW_J: begin
        t.re = -b.im;
        t.im = b.re;
      end
      TW_CJC: begin
        t.re = IW'((pr - pi) >>> TW_SHIFT);
        t.im = IW'((pr + pi) >>> TW_SHIFT);
      end
      default: begin
        t.re = IW'((-pr - pi) >>> TW_SHIFT);
        t.im = IW'((pr - pi) >>> TW_SHIFT);
      end
    endcase
  end

  always_comb begin
    s.re = a.re + t.re;
    s.im = a.im + t.im;
    d.re = a.re - t.re;
    d.im = a.im - t.im;
  end

  assign sum_o  = s;
  assign diff_o = d;

endmodule

// File: rtl/axis_ifft_8point.sv
// 8-point radix-2 DIT inverse FFT between AXI-Stream ports: one 512-bit beat of
// complex bins in, one 64-bit beat of eight saturated Q7 real samples out.
module axis_ifft_8point
  import ifft8_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_AXIS_TOUT_WIDTH  = 64
) (
  input  logic                          s_axis_clk,
  input  logic                          s_axis_areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          sat_sticky
);

  logic  en;
  cplx_t r0_d [8];
  cplx_t r0_q [8];
  cplx_t r1_d [8];
  cplx_t r1_q [8];
  cplx_t r2_d [8];
  cplx_t r2_q [8];
  cplx_t x_d  [8];
  logic [2:0] vld_q, last_q;
  logic [7:0] sat_d;
  logic [C_AXIS_TOUT_WIDTH-1:0] tdata_d, tdata_q;
  logic tvalid_q, tlast_q, tuser_q, tuser_d, sticky_q;

  // The whole pipeline moves as one; a bubble alone never frees the input.
  assign en            = ~tvalid_q | m_axis_tready;
  assign s_axis_tready = en;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cap
    assign r0_d[gi].re = IW'($signed(s_axis_tdata[64*gi+32 +: 32]));
    assign r0_d[gi].im = IW'($signed(s_axis_tdata[64*gi +: 32]));
  end

  // 2-point stage: bit-reversed pairs (0,4) (2,6) (1,5) (3,7) -> A, B, C, D.
  for (genvar gi = 0; gi < 4; gi++) begin : g_r1
    localparam int LO = ((gi & 1) << 1) | (gi >> 1);
    ifft_cbfly u_bf (
      .a_i   (r0_q[LO]),
      .b_i   (r0_q[LO+4]),
      .sel_i (TW_ONE),
      .sum_o (r1_d[2*gi]),
      .diff_o(r1_d[2*gi+1])
    );
  end

  // 4-point stage: r2[0..3] = even-bin group E[n], r2[4..7] = odd-bin group O[n].
  for (genvar gi = 0; gi < 4; gi++) begin : g_r2
    localparam int         G   = gi >> 1;
    localparam int         K   = gi & 1;
    localparam logic [1:0] SEL = (K == 1) ? TW_J : TW_ONE;
    ifft_cbfly u_bf (
      .a_i   (r1_q[4*G+K]),
      .b_i   (r1_q[4*G+K+2]),
      .sel_i (SEL),
      .sum_o (r2_d[4*G+K]),
      .diff_o(r2_d[4*G+K+2])
    );
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_r3
    localparam logic [1:0] SEL = (gi == 0) ? TW_ONE :
                                 (gi == 1) ? TW_CJC :
                                 (gi == 2) ? TW_J   : TW_NCJC;
    ifft_cbfly u_bf (
      .a_i   (r2_q[gi]),
      .b_i   (r2_q[gi+4]),
      .sel_i (SEL),
      .sum_o (x_d[gi]),
      .diff_o(x_d[gi+4])
    );
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_out
    assign {sat_d[gi], tdata_d[8*gi +: 8]} = q7_round_sat(x_d[gi].re);
  end

  assign tuser_d = vld_q[2] & (|sat_d);

  always_ff @(posedge s_axis_clk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      for (int i = 0; i < 8; i++) begin
        r0_q[i] <= '0;
        r1_q[i] <= '0;
        r2_q[i] <= '0;
      end
      vld_q    <= '0;
      last_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tdata_q  <= '0;
      sticky_q <= 1'b0;
    end else if (en) begin
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      vld_q    <= {vld_q[1:0], s_axis_tvalid};
      last_q   <= {last_q[1:0], s_axis_tvalid & s_axis_tlast};
      tvalid_q <= vld_q[2];
      tlast_q  <= last_q[2];
      tuser_q  <= tuser_d;
      tdata_q  <= tdata_d;
      sticky_q <= sticky_q | tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign sat_sticky    = sticky_q;

endmodule

// File: tb/tb_axis_ifft_8point.sv
// Self-checking bench for axis_ifft_8point: directed spectra plus randomized beats
// scored against a direct 4-point-sum inverse DFT model.
module tb_axis_ifft_8point;

  logic         clk, rst;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] s_tdata;
  logic         m_tvalid, m_tready, m_tlast, m_tuser, sat_sticky;
  logic [63:0]  m_tdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        last;
    logic        user;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_sticky;
  logic        prev_stall;
  logic [63:0] hold_data;
  logic        hold_user, hold_last;
  int          beat_n = 0;
  logic        rand_done, bp_done;
  int          stalled;

  axis_ifft_8point dut (
    .s_axis_clk   (clk),
    .s_axis_areset(rst),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .sat_sticky   (sat_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] d, input int k, input int re, input int im);
    logic [511:0] r;
    r = d;
    r[64*k+32 +: 32] = re;
    r[64*k +: 32]    = im;
    return r;
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] d;
    int a;
    d = '0;
    a = ($urandom_range(0, 1) == 1) ? 300 : 40;
    for (int k = 0; k < 8; k++)
      d = put(d, k, int'($urandom_range(0, 2*a)) - a, int'($urandom_range(0, 2*a)) - a);
    return d;
  endfunction

  // (a+jb) * j^m
  function automatic void jpow(input longint a, input longint b, input int m,
                               output longint r, output longint i);
    case (m)
      0:       begin r = a;  i = b;  end
      1:       begin r = -b; i = a;  end
      2:       begin r = -a; i = -b; end
      default: begin r = b;  i = -a; end
    endcase
  endfunction

  // x[n] = E[n] +/- W8^-n O[n], E/O as direct 4-point inverse DFTs of even/odd bins.
  function automatic void ref_ifft(input logic [511:0] d, output logic [63:0] y, output logic sat);
    longint xr[8], xi[8], er[4], ei[4], orr[4], oi[4], xv[8];
    longint tr, ti, s, c;
    c = 23170;
    for (int k = 0; k < 8; k++) begin
      xr[k] = longint'($signed(d[64*k+32 +: 32]));
      xi[k] = longint'($signed(d[64*k +: 32]));
    end
    for (int n = 0; n < 4; n++) begin
      er[n] = 0; ei[n] = 0; orr[n] = 0; oi[n] = 0;
      for (int k = 0; k < 4; k++) begin
        jpow(xr[2*k], xi[2*k], (k*n) % 4, tr, ti);
        er[n] += tr; ei[n] += ti;
        jpow(xr[2*k+1], xi[2*k+1], (k*n) % 4, tr, ti);
        orr[n] += tr; oi[n] += ti;
      end
    end
    for (int n = 0; n < 4; n++) begin
      case (n)
        0:       tr = orr[n];
        1:       tr = (orr[n]*c - oi[n]*c) >>> 15;
        2:       tr = -oi[n];
        default: tr = (-orr[n]*c - oi[n]*c) >>> 15;
      endcase
      xv[n]   = er[n] + tr;
      xv[n+4] = er[n] - tr;
    end
    y = '0;
    sat = 1'b0;
    for (int n = 0; n < 8; n++) begin
      s = (xv[n] + 4) >>> 3;
      if (s > 127) begin
        y[8*n +: 8] = 8'h7F; sat = 1'b1;
      end else if (s < -128) begin
        y[8*n +: 8] = 8'h80; sat = 1'b1;
      end else begin
        y[8*n +: 8] = s[7:0];
      end
    end
  endfunction

  // Scoreboard: handshakes are judged at the negedge before the edge that completes them.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] yd;
    logic        yu;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", m_tdata, hold_data);
        check("hold_ctl", {m_tvalid, m_tuser, m_tlast}, {1'b1, hold_user, hold_last});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_tvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("data", m_tdata, e.data);
          check("tuser", m_tuser, e.user);
          check("tlast", m_tlast, e.last);
          exp_sticky = exp_sticky | e.user;
          check("sticky", sat_sticky, exp_sticky);
          $display("beat %0d data=%h user=%0d last=%0d", beat_n, m_tdata, m_tuser, m_tlast);
          beat_n++;
        end
      end
      if (s_tvalid && s_tready) begin
        ref_ifft(s_tdata, yd, yu);
        e.data = yd;
        e.user = yu;
        e.last = s_tlast;
        exp_q.push_back(e);
      end
      prev_stall = m_tvalid && !m_tready;
      hold_data  = m_tdata;
      hold_user  = m_tuser;
      hold_last  = m_tlast;
    end
  end

  task automatic send(input logic [511:0] d, input logic l);
    int w;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_tready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("send_ready", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || m_tvalid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [511:0] d,
                          input logic [63:0] exp_data, input logic exp_user);
    drain();
    send(d, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check({tag, "_lat"}, m_tvalid, 64'(i == 4));
    end
    check({tag, "_data"}, m_tdata, exp_data);
    check({tag, "_user"}, m_tuser, exp_user);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    exp_sticky = 1'b0; prev_stall = 1'b0;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_sticky", sat_sticky, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_sready", s_tready, 1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("dc", put('0, 0, 256, 0), 64'h2020202020202020, 1'b0);
    d = '0;
    for (int k = 0; k < 8; k++) d = put(d, k, 64, 0);
    directed("flat", d, 64'h0000000000000040, 1'b0);
    directed("nyq", put('0, 4, -256, 0), 64'h20E020E020E020E0, 1'b0);
    directed("x1", put('0, 1, 256, 0), 64'h1700E9E0E9001720, 1'b0);
    directed("sat_pos", put('0, 0, 2000, 0), 64'h7F7F7F7F7F7F7F7F, 1'b1);
    check("sticky_set", sat_sticky, 1);
    directed("dc2", put('0, 0, 256, 0), 64'h2020202020202020, 1'b0);
    check("sticky_hold", sat_sticky, 1);
    directed("sat_neg", put('0, 0, -2000, 0), 64'h8080808080808080, 1'b1);

    drain();
    rand_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          send(rand_beat(), $urandom_range(0, 3) == 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    bp_done = 1'b0;
    stalled = 0;
    fork
      begin
        for (int b = 0; b < 6; b++) send(rand_beat(), b == 5);
        bp_done = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_sready", s_tready, 64'(!m_tvalid));
          if (m_tvalid) stalled++;
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    check("bp_stalled", stalled, 3);
    drain();

    check("sticky_pre_rst", sat_sticky, 1);
    m_tready = 1'b0;
    for (int b = 0; b < 4; b++) send(rand_beat(), 1'b0);
    @(negedge clk);
    check("stall_full", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_sticky", sat_sticky, 0);
    check("rst_mid_tuser", m_tuser, 0);
    exp_q.delete();
    exp_sticky = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    directed("post_rst", put('0, 0, 256, 0), 64'h2020202020202020, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
